// File: rtl/mlops_pkg.sv
// rtl/mlops_pkg.sv - shared FSM state type and fixed-point width helpers
package mlops_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  // Exact signed product of two IW.QW operands: 2*IW integer, 2*QW fractional bits
  function automatic int prod_w(input int iw, input int qw);
    return 2 * (iw + qw);
  endfunction

  // Headroom for max_len products plus the bias without overflow
  function automatic int acc_w(input int iw, input int qw, input int max_len);
    return 2 * (iw + qw) + $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/sfp_sat_resize.sv
// rtl/sfp_sat_resize.sv - signed fixed-point rescale (floor or zero-fill) with saturation
module sfp_sat_resize #(
  parameter int IN_IW  = 8,
  parameter int IN_QW  = 8,
  parameter int OUT_IW = 8,
  parameter int OUT_QW = 4
) (
  input  logic [IN_IW+IN_QW-1:0]   in_val,
  output logic [OUT_IW+OUT_QW-1:0] out_val,
  output logic                     sat
);

  localparam int IN_W  = IN_IW + IN_QW;
  localparam int OUT_W = OUT_IW + OUT_QW;
  localparam int DR    = (IN_QW > OUT_QW) ? IN_QW - OUT_QW : 0;
  localparam int SH    = (OUT_QW > IN_QW) ? OUT_QW - IN_QW : 0;
  localparam int EW    = IN_W + SH + OUT_W;

  localparam logic signed [EW-1:0] MAXV = (EW'(1) << (OUT_W - 1)) - EW'(1);
  localparam logic signed [EW-1:0] MINV = ~MAXV;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] scaled;

  // Widened first so the left shift and the range compare can never wrap
  assign ext    = {{(EW-IN_W){in_val[IN_W-1]}}, in_val};
  assign scaled = (ext >>> DR) <<< SH;

  always_comb begin
    out_val = scaled[OUT_W-1:0];
    sat     = 1'b0;
    if (scaled > MAXV) begin
      out_val = MAXV[OUT_W-1:0];
      sat     = 1'b1;
    end else if (scaled < MINV) begin
      out_val = MINV[OUT_W-1:0];
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/vec_dot_accum.sv
// rtl/vec_dot_accum.sv - streaming y = b + sum(m*x) with two-stage pipeline and held result
module vec_dot_accum
  import mlops_pkg::*;
#(
  parameter int IW      = 4,
  parameter int QW      = 4,
  parameter int MAX_LEN = 64,
  parameter int OUT_IW  = 8,
  parameter int OUT_QW  = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW+QW-1:0]         m_in,
  input  logic [IW+QW-1:0]         x_in,
  input  logic [IW+QW-1:0]         b_in,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_IW+OUT_QW-1:0] y_out,
  output logic                     y_sat
);

  localparam int W  = IW + QW;
  localparam int PW = prod_w(IW, QW);
  localparam int AW = acc_w(IW, QW, MAX_LEN);
  localparam int OW = OUT_IW + OUT_QW;
  localparam int CW = $clog2(MAX_LEN) + 1;

  state_e          state;
  logic [CW-1:0]   beat_cnt;
  logic            accept;
  logic            beat_last;
  logic [PW-1:0]   prod_c;
  logic [AW-1:0]   bias_c;

  logic            s1_valid, s1_first, s1_last;
  logic [PW-1:0]   s1_prod;
  logic [AW-1:0]   s1_bias;
  logic [AW-1:0]   acc;
  logic            acc_done;
  logic [OW-1:0]   rs_y;
  logic            rs_sat;

  assign in_ready  = rst_in && (state == ST_IDLE || state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign accept    = in_valid && in_ready;
  // Beat MAX_LEN closes the vector even without in_last
  assign beat_last = in_last || (beat_cnt == CW'(MAX_LEN - 1));

  // Low 2W bits of the sign-extended product equal the exact signed product
  assign prod_c = {{W{m_in[W-1]}}, m_in} * {{W{x_in[W-1]}}, x_in};
  assign bias_c = {{(AW-W){b_in[W-1]}}, b_in} << QW;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
    end else begin
      s1_valid <= accept;
      s1_first <= accept && (state == ST_IDLE);
      s1_last  <= accept && beat_last;
      if (accept) s1_prod <= prod_c;
      if (accept && state == ST_IDLE) s1_bias <= bias_c;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      if (s1_valid) acc <= (s1_first ? s1_bias : acc) + {{(AW-PW){s1_prod[PW-1]}}, s1_prod};
      acc_done <= s1_valid && s1_last;
    end
  end

  sfp_sat_resize #(
    .IN_IW  (AW - 2*QW),
    .IN_QW  (2*QW),
    .OUT_IW (OUT_IW),
    .OUT_QW (OUT_QW)
  ) u_resize (
    .in_val  (acc),
    .out_val (rs_y),
    .sat     (rs_sat)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      y_out    <= '0;
      y_sat    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          beat_cnt <= CW'(1);
          state    <= beat_last ? ST_DRAIN : ST_ACCUM;
        end
        ST_ACCUM: if (accept) begin
          beat_cnt <= beat_cnt + CW'(1);
          if (beat_last) state <= ST_DRAIN;
        end
        ST_DRAIN: if (acc_done) begin
          y_out <= rs_y;
          y_sat <= rs_sat;
          state <= ST_HOLD;
        end
        ST_HOLD: if (out_ready) begin
          beat_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_accum.sv
// tb/tb_vec_dot_accum.sv - randomized and directed bench against a plain-arithmetic dot-product model
module tb_vec_dot_accum;

  localparam int W       = 8;
  localparam int OW      = 12;
  localparam int MAX_LEN = 64;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  m_in = '0, x_in = '0, b_in = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] y_out;
  logic          y_sat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] vm [0:127];
  logic [W-1:0] vx [0:127];

  logic rdy_rand  = 1'b0;
  logic rdy_force = 1'b1;

  vec_dot_accum #(.IW(4), .QW(4), .MAX_LEN(MAX_LEN), .OUT_IW(8), .OUT_QW(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_in      (m_in),
    .x_in      (x_in),
    .b_in      (b_in),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .y_sat     (y_sat)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact sum in units of 2^-8, floor to 2^-4, clip to 12-bit signed
  function automatic logic [12:0] model_y(input int acc);
    int y;
    y = acc >>> 4;
    if (y > 2047)  return {1'b1, 12'h7FF};
    if (y < -2048) return {1'b1, 12'h800};
    return {1'b0, y[11:0]};
  endfunction

  logic [12:0]   exp_q [$];
  int            acc_cyc_q [$];
  int            m_acc = 0, m_cnt = 0;
  logic          prev_valid = 1'b0, prev_hs = 1'b0;
  logic [OW-1:0] held_y = '0;
  logic          held_sat = 1'b0;
  int            n_results = 0;
  logic [OW-1:0] last_y = '0;
  logic          last_sat = 1'b0;

  always @(negedge clk_in) begin
    int sm, sx, sb;
    logic [12:0] e;
    if (!rst_in) begin
      exp_q.delete();
      acc_cyc_q.delete();
      m_acc = 0; m_cnt = 0;
      prev_valid = 1'b0; prev_hs = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y_out", 32'(y_out), 32'd0);
      check("rst_y_sat", 32'(y_sat), 32'd0);
    end else begin
      if (out_valid) begin
        if (!prev_valid || prev_hs) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("y_out", 32'(y_out), 32'(e[11:0]));
            check("y_sat", 32'(y_sat), 32'(e[12]));
            check("latency", 32'(cyc - acc_cyc_q.pop_front()), 32'd2);
          end
          held_y = y_out; held_sat = y_sat;
          last_y = y_out; last_sat = y_sat;
          n_results++;
        end else begin
          check("hold_y_stable", 32'(y_out), 32'(held_y));
          check("hold_sat_stable", 32'(y_sat), 32'(held_sat));
        end
        check("in_ready_in_hold", 32'(in_ready), 32'd0);
      end
      prev_hs    = out_valid && out_ready;
      prev_valid = out_valid;
      if (in_valid && in_ready) begin
        sm = $signed(m_in); sx = $signed(x_in); sb = $signed(b_in);
        if (m_cnt == 0) m_acc = sb * 16 + sm * sx;
        else            m_acc = m_acc + sm * sx;
        m_cnt++;
        if (in_last || m_cnt == MAX_LEN) begin
          exp_q.push_back(model_y(m_acc));
          acc_cyc_q.push_back(cyc + 1);
          m_cnt = 0;
        end
      end
    end
  end

  task automatic drive_beat(input logic [W-1:0] m, input logic [W-1:0] x,
                            input logic [W-1:0] b, input logic last);
    int n;
    logic ok;
    m_in = m; x_in = x; b_in = b; in_last = last; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk_in);
      ok = in_ready;
      @(posedge clk_in);
      #1;
      n++;
    end
    if (!ok) check("beat_accept_timeout", 32'(ok), 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
    m_in = W'($urandom); x_in = W'($urandom); b_in = W'($urandom);
  endtask

  // Non-first beats carry random b to show the bias is taken only once
  task automatic send_vec(input logic [W-1:0] b, input int n, input int gap, input logic term);
    for (int i = 0; i < n; i++) begin
      drive_beat(vm[i], vx[i], (i == 0) ? b : W'($urandom), term && (i == n - 1));
      if (i < n - 1) repeat (gap) begin @(posedge clk_in); #1; end
    end
  endtask

  task automatic wait_result(input int target);
    int n;
    n = 0;
    while (n_results < target && n < 200) begin @(posedge clk_in); #1; n++; end
    if (n_results < target) check("result_timeout", 32'(n_results), 32'(target));
  endtask

  task automatic set3(input logic [W-1:0] m0, x0, m1, x1, m2, x2);
    vm[0] = m0; vx[0] = x0; vm[1] = m1; vx[1] = x1; vm[2] = m2; vx[2] = x2;
  endtask

  initial begin
    int tgt, cnt;
    check("pin_model_pos", 32'(model_y(127*127 + 127*16)), 32'h046F);
    check("pin_model_sat", 32'(model_y(3*127*127 + 127*16)), 32'h17FF);
    check("pin_model_floor", 32'(model_y(-1)), 32'h0FFF);

    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    #1 check("ready_after_release", 32'(in_ready), 32'd1);
    @(posedge clk_in); #1;

    // 1.0 + 1.5*2.0 + 1.0*(-1.0) + 0.5*4.0 = 5.0
    set3(8'h18, 8'h20, 8'h10, 8'hF0, 8'h08, 8'h40);
    tgt = n_results + 1; send_vec(8'h10, 3, 0, 1'b1); wait_result(tgt);
    check("dir_3beat_y", 32'(last_y), 32'h050);
    check("dir_3beat_sat", 32'(last_sat), 32'd0);

    vm[0] = 8'h7F; vx[0] = 8'h7F;
    tgt = n_results + 1; send_vec(8'h7F, 1, 0, 1'b1); wait_result(tgt);
    check("dir_1beat_y", 32'(last_y), 32'h46F);
    check("dir_1beat_sat", 32'(last_sat), 32'd0);

    set3(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    tgt = n_results + 1; send_vec(8'h7F, 3, 0, 1'b1); wait_result(tgt);
    check("dir_satpos_y", 32'(last_y), 32'h7FF);
    check("dir_satpos_sat", 32'(last_sat), 32'd1);

    set3(8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F);
    tgt = n_results + 1; send_vec(8'h80, 3, 0, 1'b1); wait_result(tgt);
    check("dir_satneg_y", 32'(last_y), 32'h800);
    check("dir_satneg_sat", 32'(last_sat), 32'd1);

    vm[0] = 8'h01; vx[0] = 8'h01;
    tgt = n_results + 1; send_vec(8'h00, 1, 0, 1'b1); wait_result(tgt);
    check("dir_floor_pos", 32'(last_y), 32'h000);
    vm[0] = 8'hFF; vx[0] = 8'h01;
    tgt = n_results + 1; send_vec(8'h00, 1, 0, 1'b1); wait_result(tgt);
    check("dir_floor_neg", 32'(last_y), 32'hFFF);

    // Gapped input and a stalled consumer
    rdy_force = 1'b0;
    set3(8'h18, 8'h20, 8'h10, 8'hF0, 8'h08, 8'h40);
    tgt = n_results + 1; send_vec(8'h10, 3, 2, 1'b1); wait_result(tgt);
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    check("hold_still_valid", 32'(out_valid), 32'd1);
    check("hold_gap_y", 32'(y_out), 32'h050);
    rdy_force = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 check("hold_released", 32'(out_valid), 32'd0);

    // Reset mid-vector drops the partial result
    vm[0] = 8'h33; vx[0] = 8'h21; vm[1] = 8'h12; vx[1] = 8'h44;
    send_vec(8'h05, 2, 0, 1'b0);
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    cnt = 0;
    repeat (10) begin @(negedge clk_in); if (out_valid) cnt++; end
    check("no_out_after_reset", 32'(cnt), 32'd0);
    @(posedge clk_in); #1;
    vm[0] = 8'h10; vx[0] = 8'h10;
    tgt = n_results + 1; send_vec(8'h20, 1, 0, 1'b1); wait_result(tgt);
    check("post_reset_y", 32'(last_y), 32'h030);

    // 65 beats with no in_last: forced end at 64, beat 65 opens a new vector
    for (int i = 0; i < MAX_LEN; i++) begin vm[i] = W'($urandom); vx[i] = W'($urandom); end
    tgt = n_results + 2;
    send_vec(W'($urandom), MAX_LEN, 0, 1'b0);
    vm[0] = 8'h10; vx[0] = 8'h20;
    send_vec(8'h30, 1, 0, 1'b1);
    wait_result(tgt);
    check("beat65_new_vec_y", 32'(last_y), 32'h050);

    rdy_rand = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin vm[i] = W'($urandom); vx[i] = W'($urandom); end
      send_vec(W'($urandom), len, $urandom_range(0, 2), 1'b1);
    end
    tgt = n_results + exp_q.size();
    wait_result(tgt);
    repeat (5) @(posedge clk_in);
    #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
